// File: rtl/hex_display_arbiter_if.sv
// Request/display bundle between the requesting user logic and the HEX0 display arbiter.
// Arbiter consumes req/data and drives grant/HEX0/busy.
interface hex_display_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0]   grant;
  logic [6:0]           HEX0;
  logic                 busy;

  modport master (output req, output data, input grant, input HEX0, input busy);
  modport slave  (input req, input data, output grant, output HEX0, output busy);
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin, non-preemptive sharing of one active-low 7-segment digit among NUM_REQ requesters.
// Define BLANK_GAP_EN to insert GAP_CYCLES blank clocks between consecutive grants.
module hex_display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  Resetn,
  hex_display_arbiter_if.slave  bus
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef BLANK_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`endif
  localparam logic [PTR_W-1:0]   LAST_RST  = PTR_W'(NUM_REQ - 1);
  localparam logic [6:0]         SEG_BLANK = 7'h7F;
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

`ifdef BLANK_GAP_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHOW = 2'd1, ST_GAP = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHOW = 2'd1} state_e;
`endif

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [6:0]           hex_q, hex_d;
  logic                 busy_q, busy_d;

  logic                 any_s;
  logic [PTR_W-1:0]     win_s;
  logic [3:0]           win_data_s;
  logic                 take_s;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Round-robin search starting just after the previous owner.
  always_comb begin
    any_s      = 1'b0;
    win_s      = '0;
    win_data_s = 4'h0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int idx;
      idx = (int'(last_q) + off) % NUM_REQ;
      if (!any_s && bus.req[idx]) begin
        any_s      = 1'b1;
        win_s      = idx[PTR_W-1:0];
        win_data_s = bus.data[4*idx +: 4];
      end else begin
        any_s      = any_s;
      end
    end
  end

  // State and registered outputs; reset is synchronous.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      grant_q <= '0;
      hex_q   <= SEG_BLANK;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      hex_q   <= hex_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) state_d = ST_SHOW;
        else       state_d = ST_IDLE;
      end
      ST_SHOW: begin
        if (cnt_q == HOLD_LAST) begin
`ifdef BLANK_GAP_EN
          state_d = ST_GAP;
`else
          if (any_s) state_d = ST_SHOW;
          else       state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_SHOW;
        end
      end
`ifdef BLANK_GAP_EN
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (any_s) state_d = ST_SHOW;
          else       state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // A fresh grant happens whenever SHOW is entered or re-entered at hold expiry.
  assign take_s = (state_d == ST_SHOW) && ((state_q != ST_SHOW) || (cnt_q == HOLD_LAST));

  // Next values of counter, pointer and the registered outputs.
  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    hex_d   = hex_q;
    busy_d  = busy_q;
    if (take_s) begin
      cnt_d   = '0;
      last_d  = win_s;
      grant_d = ONE_HOT0 << win_s;
      hex_d   = seg7(win_data_s);
      busy_d  = 1'b1;
    end else if (state_d == ST_SHOW) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (state_d == ST_IDLE) begin
      cnt_d   = '0;
      grant_d = '0;
      hex_d   = SEG_BLANK;
      busy_d  = 1'b0;
    end else begin
      if (state_q == state_d) cnt_d = cnt_q + CNT_W'(1);
      else                    cnt_d = '0;
      grant_d = '0;
      hex_d   = SEG_BLANK;
      busy_d  = 1'b1;
    end
  end

  assign bus.grant = grant_q;
  assign bus.HEX0  = hex_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed, table-driven bench for hex_display_arbiter with HOLD_CYCLES=4, NUM_REQ=4, GAP_CYCLES=2.
module tb_hex_display_arbiter;
  localparam int NR   = 4;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
`ifdef BLANK_GAP_EN
  localparam int EXP_GAP = 2;
`else
  localparam int EXP_GAP = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  hex_display_arbiter_if #(.NUM_REQ(NR)) bus ();

  hex_display_arbiter #(
    .NUM_REQ(NR), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut (
    .CLOCK_50(clk),
    .Resetn(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  grant;
    logic [6:0]  hex;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  function automatic void addn(input int n, input logic r, input logic [3:0] rq, input logic [15:0] d,
                               input logic [3:0] g, input logic [6:0] h, input logic b);
    vec_t v;
    v.rstn = r; v.req = rq; v.data = d; v.grant = g; v.hex = h; v.busy = b;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    int g_cycles;
    int b_cycles;
    bus.req  = 4'h0;
    bus.data = 16'h0000;

    // reset with all requests asserted
    addn(2, 1'b0, 4'hF, 16'h3210, 4'b0000, 7'h7F, 1'b0);
`ifndef BLANK_GAP_EN
    // rotation, back-to-back
    addn(4, 1'b1, 4'hF, 16'h3210, 4'b0001, 7'h40, 1'b1);
    addn(4, 1'b1, 4'hF, 16'h3210, 4'b0010, 7'h79, 1'b1);
    addn(4, 1'b1, 4'hF, 16'h3210, 4'b0100, 7'h24, 1'b1);
    addn(4, 1'b1, 4'hF, 16'h3210, 4'b1000, 7'h30, 1'b1);
    addn(4, 1'b1, 4'hF, 16'h3210, 4'b0001, 7'h40, 1'b1);
    addn(1, 1'b1, 4'h0, 16'h3210, 4'b0000, 7'h7F, 1'b0);
    // lone requester re-granted without a blank cycle
    addn(8, 1'b1, 4'b0100, 16'h0A00, 4'b0100, 7'h08, 1'b1);
    addn(1, 1'b1, 4'b0000, 16'h0A00, 4'b0000, 7'h7F, 1'b0);
`else
    // grant, blank gap, next grant, gap, idle
    addn(4, 1'b1, 4'b0011, 16'h3210, 4'b0001, 7'h40, 1'b1);
    addn(2, 1'b1, 4'b0011, 16'h3210, 4'b0000, 7'h7F, 1'b1);
    addn(4, 1'b1, 4'b0011, 16'h3210, 4'b0010, 7'h79, 1'b1);
    addn(2, 1'b1, 4'b0000, 16'h3210, 4'b0000, 7'h7F, 1'b1);
    addn(1, 1'b1, 4'b0000, 16'h3210, 4'b0000, 7'h7F, 1'b0);
`endif
    // latched value survives data change and request drop
    addn(1, 1'b1, 4'b0010, 16'h0050, 4'b0010, 7'h12, 1'b1);
    addn(3, 1'b1, 4'b0000, 16'h0090, 4'b0010, 7'h12, 1'b1);
`ifdef BLANK_GAP_EN
    addn(2, 1'b1, 4'b0000, 16'h0090, 4'b0000, 7'h7F, 1'b1);
`endif
    addn(1, 1'b1, 4'b0000, 16'h0090, 4'b0000, 7'h7F, 1'b0);
    // reset in the middle of a hold
    addn(3, 1'b1, 4'hF, 16'h3210, 4'b0100, 7'h24, 1'b1);
    addn(1, 1'b0, 4'hF, 16'h3210, 4'b0000, 7'h7F, 1'b0);
    addn(1, 1'b1, 4'hF, 16'h3210, 4'b0001, 7'h40, 1'b1);
    addn(1, 1'b0, 4'h0, 16'h3210, 4'b0000, 7'h7F, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n    = vecs[i].rstn;
      bus.req  = vecs[i].req;
      bus.data = vecs[i].data;
      @(posedge clk);
      #1;
      checks++;
      if (bus.grant !== vecs[i].grant || bus.HEX0 !== vecs[i].hex || bus.busy !== vecs[i].busy) begin
        errors++;
        $display("FAIL vec%0d grant/hex/busy: got %b/%h/%b expected %b/%h/%b", i,
                 bus.grant, bus.HEX0, bus.busy, vecs[i].grant, vecs[i].hex, vecs[i].busy);
      end
    end

    // one-edge request pulse: grant length and trailing busy time
    @(negedge clk);
    rst_n    = 1'b1;
    bus.req  = 4'b1000;
    bus.data = 16'hE000;
    @(posedge clk);
    #1;
    check("pulse_grant", {28'd0, bus.grant}, 32'h8);
    check("pulse_hex", {25'd0, bus.HEX0}, 32'h06);
    bus.req = 4'b0000;
    g_cycles = 1;
    for (int k = 0; k < 20 && bus.grant == 4'b1000; k++) begin
      @(posedge clk);
      #1;
      if (bus.grant == 4'b1000) g_cycles++;
    end
    check("pulse_hold_len", g_cycles, HOLD);
    b_cycles = 0;
    for (int j = 0; j < 20 && bus.busy; j++) begin
      b_cycles++;
      @(posedge clk);
      #1;
    end
    check("pulse_gap_len", b_cycles, EXP_GAP);
    check("pulse_end_hex", {25'd0, bus.HEX0}, 32'h7F);
    check("pulse_end_grant", {28'd0, bus.grant}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
